npc_btb_predict: RTL and testbench
==================================

// Module: npc_btb_predict
// PURPOSE
//  Next-PC unit for the 5-stage pipeline with a direct-mapped branch target buffer (BTB)
//  and 2-bit saturating counters. IF looks up the BTB on if_pc and steers if_npc; EX
//  resolves jal/jalr/B-type, trains the BTB and redirects plus flushes on mispredict.
//  Drives the PC register input; also carries ex_pc+4 back for jal/jalr writeback.
// PARAMETERS
//  XLEN       32            data/address width
//  BTB_DEPTH  16            BTB entries, power of 2, >=2
//  IDX_W      $clog2(DEPTH) index width (derived localparam)
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     synchronous reset, active-high
//  stop            in   1     IF stall (hold PC)
//  if_pc           in   XLEN  current fetch PC
//  if_npc          out  XLEN  next fetch PC
//  if_pred_taken   out  1     prediction for if_pc; piped to EX by pipeline regs
//  if_pred_target  out  XLEN  predicted target for if_pc
//  ex_op           in   2     00 none, 01 jalr, 10 B-type, 11 jal
//  ex_if_branch    in   1     B-type condition result (valid when ex_op==10)
//  ex_pc           in   XLEN  PC of instr in EX
//  ex_ra           in   XLEN  rs1 value (jalr base)
//  ex_imm          in   XLEN  sign-extended immediate
//  ex_pred_taken   in   1     if_pred_taken piped to EX
//  ex_pred_target  in   XLEN  if_pred_target piped to EX
//  ex_pc4          out  XLEN  ex_pc + 4
//  flush           out  1     mispredict: kill IF/ID instrs
//  perf_ctrl_cnt   out  32    resolved control instrs (macro)
//  perf_mispred_cnt out 32    mispredicts (macro)
// BEHAVIOUR
//  - Entry: valid, tag=pc[XLEN-1:IDX_W+2], target[XLEN], ctr[2]; index=pc[IDX_W+1:2].
//  - Lookup (comb): hit = valid & tag match; if_pred_taken = hit & ctr[1];
//    if_pred_target = entry target (0 on miss).
//  - Actual: taken = (op==01)|(op==11)|(op==10 & ex_if_branch);
//    target: 11/10 -> ex_pc+ex_imm; 01 -> (ex_ra+ex_imm) & ~1. Sums mod 2^XLEN.
//  - Mispredict (op!=00 only): taken & (!ex_pred_taken | ex_pred_target!=target), or
//    !taken & ex_pred_taken. flush = mispredict, combinational, same cycle.
//  - if_npc priority: mispredict -> (taken ? target : ex_pc4); else stop -> if_pc;
//    else if_pred_taken -> if_pred_target; else if_pc+4. Redirect overrides stop.
//  - Training on clk edge when op!=00 (independent of stop):
//    hit: B-type taken ctr=min(ctr+1,3), not-taken ctr=max(ctr-1,0); jal/jalr ctr=3;
//    target<=actual target when taken.
//    miss & taken: allocate/overwrite: valid=1, tag, target, ctr=2 (B) or 3 (jal/jalr).
//    miss & not-taken: no write.
//  - Same-index read in IF and write from EX in one cycle: IF sees old entry (write
//    visible next cycle).
//  - Reset: all valid=0, ctr=1, target=0; perf counters=0. During rst no training.
//    Comb outputs reflect cleared table (if_pred_taken=0) from first post-reset cycle.
//  - ex_pc4 = ex_pc+4 always.
// CONFIGURATION
//  NPC_PERF_CNT_EN defined: perf_ctrl_cnt +1 per cycle op!=00; perf_mispred_cnt +1 per
//    mispredict; both 32-bit, wrap at 2^32, cleared by rst.
//  Not defined: no counter flops; both ports tied to 0.
// TESTING
//  1 rst, op=00, if_pc=0x100, stop=0 -> if_npc=0x104, pred_taken=0, flush=0.
//  2 B-type at ex_pc=0x200 imm=0x40 taken, ex_pred_taken=0 -> flush=1, if_npc=0x240;
//    next cycle if_pc=0x200 -> pred_taken=1 (ctr=2), target=0x240.
//  3 same branch not-taken twice with pred=1 -> 1st flush, if_npc=0x204, ctr=1;
//    later if_pc=0x200 predicts not-taken; 2nd resolution no flush (pred=0).
//  4 jalr ex_ra=0x1001 imm=0x10, pred target 0x1010 -> target 0x1010, flush=0;
//    pred target 0x2000 -> flush=1, if_npc=0x1010; ex_pc4=ex_pc+4.
//  5 aliasing: 0x200 and 0x200+4*BTB_DEPTH both taken -> second evicts first;
//    stop=1 with mispredict -> redirect wins; stop=1 alone -> if_npc=if_pc.
//  6 NPC_PERF_CNT_EN: 10 control instrs with 3 mispredicts -> counts 10/3; rst mid-run
//    clears both and BTB (pred_taken=0 next cycle).

Source files
------------

// File: rtl/npc_btb_predict.sv
// Next-PC unit: direct-mapped BTB with 2-bit saturating counters, trained and redirected from EX.
// Optional macro NPC_PERF_CNT_EN adds control-instruction and mispredict counters.
module npc_btb_predict #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stop,
  input  logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_npc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic [1:0]      ex_op,
  input  logic            ex_if_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_ra,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] ex_pc4,
  output logic            flush,
  output logic [31:0]     perf_ctrl_cnt,
  output logic [31:0]     perf_mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_JALR = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_JAL  = 2'b11;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic             btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]  btb_target [BTB_DEPTH];
  logic [1:0]       btb_ctr    [BTB_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;
  logic             if_hit;
  logic             ex_hit;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;
  logic             mispredict;

  // Saturating 2-bit counter step toward taken (up) or not-taken.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    if (up) res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    else    res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    return res;
  endfunction

  // jalr target: base + offset with bit 0 forced low.
  function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] base,
                                                  input logic [XLEN-1:0] ofs);
    logic [XLEN-1:0] sum;
    sum    = base + ofs;
    sum[0] = 1'b0;
    return sum;
  endfunction

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

  assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

  // IF lookup reads the registered table, so an EX write this cycle shows up next cycle.
  assign if_pred_taken  = if_hit & btb_ctr[if_idx][1];
  assign if_pred_target = if_hit ? btb_target[if_idx] : '0;

  assign ex_pc4 = ex_pc + PC_STEP;

  always_comb begin
    ex_taken  = 1'b0;
    ex_target = ex_pc + ex_imm;
    case (ex_op)
      OP_JALR: begin
        ex_taken  = 1'b1;
        ex_target = jalr_target(ex_ra, ex_imm);
      end
      OP_BR:   ex_taken = ex_if_branch;
      OP_JAL:  ex_taken = 1'b1;
      default: ex_taken = 1'b0;
    endcase
  end

  always_comb begin
    mispredict = 1'b0;
    if (ex_op != OP_NONE) begin
      if (ex_taken) mispredict = !ex_pred_taken || (ex_pred_target != ex_target);
      else          mispredict = ex_pred_taken;
    end
  end

  assign flush = mispredict;

  // A redirect from EX must win over an IF stall, otherwise the wrong path is held.
  always_comb begin
    if (mispredict)         if_npc = ex_taken ? ex_target : ex_pc4;
    else if (stop)          if_npc = if_pc;
    else if (if_pred_taken) if_npc = if_pred_target;
    else                    if_npc = if_pc + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'd1;
      end
    end else if (ex_op != OP_NONE) begin
      if (ex_hit) begin
        btb_ctr[ex_idx] <= (ex_op == OP_BR) ? ctr_update(btb_ctr[ex_idx], ex_taken) : 2'd3;
        if (ex_taken) btb_target[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ex_target;
        btb_ctr[ex_idx]    <= (ex_op == OP_BR) ? 2'd2 : 2'd3;
      end
    end
  end

`ifdef NPC_PERF_CNT_EN
  logic [31:0] ctrl_cnt;
  logic [31:0] mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_cnt    <= '0;
      mispred_cnt <= '0;
    end else begin
      if (ex_op != OP_NONE) ctrl_cnt    <= ctrl_cnt + 32'd1;
      if (mispredict)       mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign perf_ctrl_cnt    = ctrl_cnt;
  assign perf_mispred_cnt = mispred_cnt;
`else
  assign perf_ctrl_cnt    = '0;
  assign perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_btb_predict.sv
// Randomized + directed bench for npc_btb_predict against a behavioural BTB model.
module tb_npc_btb_predict;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, stop;
  logic [31:0] if_pc, if_npc, if_pred_target;
  logic        if_pred_taken;
  logic [1:0]  ex_op;
  logic        ex_if_branch, ex_pred_taken, flush;
  logic [31:0] ex_pc, ex_ra, ex_imm, ex_pred_target, ex_pc4;
  logic [31:0] perf_ctrl_cnt, perf_mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  npc_btb_predict #(.XLEN(XLEN), .BTB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stop(stop), .if_pc(if_pc), .if_npc(if_npc),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_op(ex_op), .ex_if_branch(ex_if_branch), .ex_pc(ex_pc), .ex_ra(ex_ra),
    .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_pc4(ex_pc4), .flush(flush), .perf_ctrl_cnt(perf_ctrl_cnt),
    .perf_mispred_cnt(perf_mispred_cnt)
  );

  // Behavioural model: each slot remembers the full PC that owns it.
  bit          m_v   [DEPTH];
  logic [31:0] m_pc  [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_ctr [DEPTH];
  logic [31:0] m_nctrl, m_nmis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_idx(pc);
    return m_v[i] && (m_pc[i] / (4 * DEPTH) == pc / (4 * DEPTH));
  endfunction

  task automatic m_resolve(output bit tk, output logic [31:0] tgt, output bit mis);
    tk  = (ex_op == 2'b01) || (ex_op == 2'b11) || (ex_op == 2'b10 && ex_if_branch);
    tgt = (ex_op == 2'b01) ? ((ex_ra + ex_imm) & 32'hFFFF_FFFE) : ex_pc + ex_imm;
    if (ex_op == 2'b00) mis = 1'b0;
    else if (tk)        mis = !ex_pred_taken || ex_pred_target != tgt;
    else                mis = ex_pred_taken;
  endtask

  task automatic m_eval(output bit pt, output logic [31:0] ptg, output logic [31:0] npc,
                        output bit fl);
    bit tk, mis;
    logic [31:0] at;
    int i = m_idx(if_pc);
    pt  = m_hit(if_pc) && m_ctr[i] >= 2;
    ptg = m_hit(if_pc) ? m_tgt[i] : 32'd0;
    m_resolve(tk, at, mis);
    fl = mis;
    if (mis)     npc = tk ? at : ex_pc + 32'd4;
    else if (stop) npc = if_pc;
    else if (pt) npc = ptg;
    else         npc = if_pc + 32'd4;
  endtask

  always @(posedge clk) begin
    bit tk, mis;
    logic [31:0] at;
    int i;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_v[k] = 1'b0; m_ctr[k] = 1; m_tgt[k] = 32'd0; m_pc[k] = 32'd0;
      end
      m_nctrl = 32'd0;
      m_nmis  = 32'd0;
    end else if (ex_op != 2'b00) begin
      m_resolve(tk, at, mis);
      m_nctrl = m_nctrl + 32'd1;
      if (mis) m_nmis = m_nmis + 32'd1;
      i = m_idx(ex_pc);
      if (m_hit(ex_pc)) begin
        if (ex_op == 2'b10) m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        else m_ctr[i] = 3;
        if (tk) m_tgt[i] = at;
      end else if (tk) begin
        m_v[i] = 1'b1; m_pc[i] = ex_pc; m_tgt[i] = at;
        m_ctr[i] = (ex_op == 2'b10) ? 2 : 3;
      end
    end
  end

  // Single compare process: every negedge once the model is in a known state.
  always @(negedge clk) begin
    bit pt, fl;
    logic [31:0] ptg, npc;
    if (chk_en) begin
      m_eval(pt, ptg, npc, fl);
      chk("pred_taken", {31'd0, if_pred_taken}, {31'd0, pt});
      chk("pred_target", if_pred_target, ptg);
      chk("if_npc", if_npc, npc);
      chk("flush", {31'd0, flush}, {31'd0, fl});
      chk("ex_pc4", ex_pc4, ex_pc + 32'd4);
`ifdef NPC_PERF_CNT_EN
      chk("perf_ctrl", perf_ctrl_cnt, m_nctrl);
      chk("perf_mis", perf_mispred_cnt, m_nmis);
`else
      chk("perf_ctrl_tied", perf_ctrl_cnt, 32'd0);
      chk("perf_mis_tied", perf_mispred_cnt, 32'd0);
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] ra,
                        input logic [31:0] imm, input bit br, input bit pt,
                        input logic [31:0] ptg);
    ex_op = op; ex_pc = pc; ex_ra = ra; ex_imm = imm;
    ex_if_branch = br; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic idle_ex();
    set_ex(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] imms [5];
    pool = '{32'h200, 32'h204, 32'h208, 32'h240, 32'h244, 32'h280, 32'h600, 32'h1000};
    imms = '{32'h40, 32'h80, 32'hFFFF_FFF8, 32'h100, 32'h0};

    rst = 1'b1; stop = 1'b0; if_pc = 32'h100;
    idle_ex();
    next_cycle(); next_cycle();
    rst = 1'b0;
    chk_en = 1'b1;

    // Cleared table: sequential fetch.
    #3;
    chk("t1_npc", if_npc, 32'h104);
    chk("t1_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("t1_flush", {31'd0, flush}, 32'd0);
    next_cycle();

    // Taken B-type with no prediction allocates ctr=2.
    set_ex(2'b10, 32'h200, 32'h0, 32'h40, 1'b1, 1'b0, 32'h0);
    #3;
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_npc", if_npc, 32'h240);
    next_cycle();
    idle_ex(); if_pc = 32'h200;
    #3;
    chk("t2_pred", {31'd0, if_pred_taken}, 32'd1);
    chk("t2_tgt", if_pred_target, 32'h240);
    next_cycle();

    // Not-taken twice: first mispredicts, second is predicted not-taken.
    if_pc = 32'h100;
    set_ex(2'b10, 32'h200, 32'h0, 32'h40, 1'b0, 1'b1, 32'h240);
    #3;
    chk("t3_flush1", {31'd0, flush}, 32'd1);
    chk("t3_npc1", if_npc, 32'h204);
    next_cycle();
    idle_ex(); if_pc = 32'h200;
    #3;
    chk("t3_pred", {31'd0, if_pred_taken}, 32'd0);
    next_cycle();
    if_pc = 32'h100;
    set_ex(2'b10, 32'h200, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0);
    #3;
    chk("t3_flush2", {31'd0, flush}, 32'd0);
    chk("t3_npc2", if_npc, 32'h104);
    next_cycle();

    // jalr clears bit 0 of the sum.
    set_ex(2'b01, 32'h300, 32'h1001, 32'h10, 1'b0, 1'b1, 32'h1010);
    #3;
    chk("t4_flush_ok", {31'd0, flush}, 32'd0);
    chk("t4_pc4", ex_pc4, 32'h304);
    next_cycle();
    set_ex(2'b01, 32'h300, 32'h1001, 32'h10, 1'b0, 1'b1, 32'h2000);
    #3;
    chk("t4_flush_bad", {31'd0, flush}, 32'd1);
    chk("t4_npc", if_npc, 32'h1010);
    next_cycle();

    // Aliasing: 0x200 and 0x240 share a slot.
    set_ex(2'b11, 32'h200, 32'h0, 32'h80, 1'b0, 1'b0, 32'h0);
    next_cycle();
    set_ex(2'b11, 32'h240, 32'h0, 32'h100, 1'b0, 1'b0, 32'h0);
    next_cycle();
    idle_ex(); if_pc = 32'h200;
    #3;
    chk("t5_evicted", {31'd0, if_pred_taken}, 32'd0);
    next_cycle();
    if_pc = 32'h240;
    #3;
    chk("t5_owner", if_npc, 32'h340);
    next_cycle();
    stop = 1'b1;
    set_ex(2'b11, 32'h500, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0);
    #3;
    chk("t5_redirect_wins", if_npc, 32'h508);
    next_cycle();
    idle_ex();
    #3;
    chk("t5_stall", if_npc, 32'h240);
    next_cycle();
    stop = 1'b0;

    // Same-slot write is invisible to IF until the next cycle.
    if_pc = 32'h600;
    set_ex(2'b11, 32'h600, 32'h0, 32'h20, 1'b0, 1'b0, 32'h0);
    #3;
    chk("t5_rw_old", {31'd0, if_pred_taken}, 32'd0);
    next_cycle();
    idle_ex();
    #3;
    chk("t5_rw_new", if_npc, 32'h620);
    next_cycle();

`ifdef NPC_PERF_CNT_EN
    rst = 1'b1; next_cycle(); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_ex(2'b11, 32'h700, 32'h0, 32'h10, 1'b0, k >= 3, 32'h710);
      next_cycle();
    end
    idle_ex(); if_pc = 32'h700;
    #3;
    chk("t6_ctrl", perf_ctrl_cnt, 32'd10);
    chk("t6_mis", perf_mispred_cnt, 32'd3);
    next_cycle();
    rst = 1'b1; next_cycle(); rst = 1'b0;
    #3;
    chk("t6_ctrl_rst", perf_ctrl_cnt, 32'd0);
    chk("t6_pred_rst", {31'd0, if_pred_taken}, 32'd0);
    next_cycle();
`endif

    // Randomized traffic over a small PC pool so entries hit, alias and retrain.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] p;
      int i;
      rst    = ($urandom_range(0, 99) == 0);
      stop   = ($urandom_range(0, 4) == 0);
      if_pc  = pool[$urandom_range(0, 7)];
      p      = pool[$urandom_range(0, 7)];
      ex_op  = 2'($urandom_range(0, 3));
      ex_pc  = p;
      ex_ra  = $urandom;
      ex_imm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0FFC) : imms[$urandom_range(0, 4)];
      ex_if_branch = $urandom_range(0, 1);
      i = m_idx(p);
      if ($urandom_range(0, 9) < 7) begin
        ex_pred_taken  = m_hit(p) && m_ctr[i] >= 2;
        ex_pred_target = m_hit(p) ? m_tgt[i] : 32'd0;
      end else begin
        ex_pred_taken  = $urandom_range(0, 1);
        ex_pred_target = p + imms[$urandom_range(0, 4)];
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
